serial_byte_tx: RTL and testbench
=================================

Name: serial_byte_tx

Overview:
- Parallel-to-serial stage feeding the 8-bit serial-in shift register downstream.
- Accepts a byte over a valid/ready handshake and emits it MSB-first, one bit per clk_sr cycle, on ser_out.
- Emits an optional inter-frame idle gap between bytes.
- Provides ser_valid and frame_done so the consumer can qualify and frame the bitstream.

Parameters:
- WIDTH, 8, data word width in bits (legal range 2..32).
- GAP_CYCLES, 0, idle cycles forced between the last bit of one frame and the next accept (legal range 0..255).

Ports:
- clk_sr  input  1  serial clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- tx_data  input  WIDTH  parallel word to send; sampled only on an accept.
- tx_valid  input  1  producer has a word on tx_data.
- tx_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit, MSB first; 0 when ser_valid=0.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- frame_done  output  1  one-cycle pulse coincident with the final bit of a frame.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst=1 at posedge): state IDLE, bit counter 0, gap counter 0, shift register 0.
  - Outputs after reset: tx_ready=1, ser_out=0, ser_valid=0, frame_done=0, busy=0.
  - Reset has priority over every other event, including an accept in the same cycle.
  - Reset mid-frame aborts the frame immediately. No frame_done is produced, and the partial frame is not resumed.
- Accept: accept = tx_valid & tx_ready, sampled at posedge.
  - tx_ready is a registered output, 1 only in IDLE.
  - tx_data is captured into an internal WIDTH-bit register on accept.
  - tx_data changes while not accepting have no effect.
- States:
  - IDLE: tx_ready=1, ser_valid=0. On accept -> SHIFT, with bit counter = WIDTH-1.
  - SHIFT: ser_out = captured[WIDTH-1] of the current shifted value; ser_valid=1. Shift left by 1 each cycle; the bit counter decrements.
    - When the counter is 0 (last data bit): frame_done=1.
    - Next state is PARITY if the optional feature is enabled. Otherwise GAP if GAP_CYCLES>0, else IDLE.
  - PARITY (feature only): see Optional Feature. Next state is GAP or IDLE, by the same rule as SHIFT.
  - GAP: ser_valid=0, ser_out=0, tx_ready=0. Lasts exactly GAP_CYCLES cycles, then -> IDLE.
- Latency: word accepted at edge k. MSB appears on ser_out in the cycle after edge k, bit i (counting from the MSB) in the cycle after edge k+i. The downstream register captures that bit at edge k+1+i.
- Throughput, GAP_CYCLES=0, no parity: one frame per WIDTH+1 cycles (WIDTH bits plus 1 IDLE accept cycle). No back-to-back accept in the last SHIFT cycle.
- tx_valid held high continuously: a new word is accepted on the first IDLE cycle.
- tx_valid dropping while tx_ready=0: no effect. The producer must hold tx_valid and tx_data until accepted.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SERIAL_BYTE_TX_PARITY_EN.
- Defined: after the last data bit, one extra PARITY cycle drives ser_out = even parity (XOR of all WIDTH captured bits), with ser_valid=1.
  - frame_done moves to the PARITY cycle; it is not asserted on the last data bit.
  - Frame length is WIDTH+1 bits.
- Undefined: no PARITY state exists; frame length is WIDTH bits and frame_done is on the last data bit.

Test Plan:
- Reset, then tx_data=8'hA5 with tx_valid=1 -> ser_out over 8 consecutive cycles = 1,0,1,0,0,1,0,1 with ser_valid=1. frame_done high only on the 8th bit. After 8 shifts the downstream register holds 8'hA5.
- Back-to-back 8'hFF then 8'h00, tx_valid held high, GAP_CYCLES=0 -> tx_ready low for exactly 8 cycles per frame, with one IDLE cycle between frames. Bitstream is eight 1s, a 0/invalid cycle, then eight 0s.
- GAP_CYCLES=3, two words 8'h81, 8'h7E -> exactly 3 cycles with ser_valid=0 and tx_ready=0 after the first frame_done, then 1 IDLE cycle before the second frame starts.
- rst=1 asserted on the 4th bit of 8'hC3 -> next cycle ser_valid=0, busy=0, tx_ready=1, with no frame_done. A following 8'h3C is sent intact.
- Simultaneous rst=1 and tx_valid=1 in IDLE -> word not accepted; busy stays 0.
- With SERIAL_BYTE_TX_PARITY_EN: 8'h07 -> 8 data bits then a parity bit of 1, with frame_done on the parity cycle. 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/serial_byte_tx_if.sv
// Handshake and serial-output bundle for serial_byte_tx.
// The master side is the producer and consumer; the slave side is the transmitter.
interface serial_byte_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_done;
  logic             busy;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, ser_out, ser_valid, frame_done, busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, ser_out, ser_valid, frame_done, busy
  );
endinterface

// File: rtl/serial_byte_tx.sv
// Parallel-to-serial transmitter: accepts a word on valid/ready and shifts it out MSB-first.
// Optional even-parity trailer bit when SERIAL_BYTE_TX_PARITY_EN is defined.
module serial_byte_tx #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic           clk_sr,
  input  logic           rst,
  serial_byte_tx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_e;

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  BIT_LAST = CW'(WIDTH - 1);
  localparam logic [7:0]     GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
`ifdef SERIAL_BYTE_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic             tx_ready_q, tx_ready_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             end_frame;
`ifdef SERIAL_BYTE_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign accept = bus.tx_valid & tx_ready_q;

  // Outputs are computed for the state being entered, so every port comes straight from a flop.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    tx_ready_d   = 1'b0;
    ser_out_d    = 1'b0;
    ser_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = 1'b1;
    end_frame    = 1'b0;
`ifdef SERIAL_BYTE_TX_PARITY_EN
    parity_d     = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = SHIFT;
          shift_d     = bus.tx_data;
          bit_cnt_d   = BIT_LAST;
          ser_out_d   = bus.tx_data[WIDTH-1];
          ser_valid_d = 1'b1;
`ifdef SERIAL_BYTE_TX_PARITY_EN
          parity_d    = ^bus.tx_data;
`endif
        end else begin
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end
      SHIFT: begin
        if (bit_cnt_q != '0) begin
          shift_d      = {shift_q[WIDTH-2:0], 1'b0};
          bit_cnt_d    = bit_cnt_q - CW'(1);
          ser_out_d    = shift_q[WIDTH-2];
          ser_valid_d  = 1'b1;
          frame_done_d = (bit_cnt_q == CW'(1)) && !PAR_EN;
        end else begin
`ifdef SERIAL_BYTE_TX_PARITY_EN
          state_d      = PARITY;
          ser_out_d    = parity_q;
          ser_valid_d  = 1'b1;
          frame_done_d = 1'b1;
`else
          end_frame    = 1'b1;
`endif
        end
      end
`ifdef SERIAL_BYTE_TX_PARITY_EN
      PARITY: end_frame = 1'b1;
`endif
      GAP: begin
        if (gap_cnt_q != 8'd0) begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end else begin
          state_d    = IDLE;
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (end_frame) begin
      if (GAP_CYCLES > 0) begin
        state_d   = GAP;
        gap_cnt_d = GAP_LAST;
      end else begin
        state_d    = IDLE;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_sr) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      tx_ready_q   <= 1'b1;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SERIAL_BYTE_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      tx_ready_q   <= tx_ready_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
`ifdef SERIAL_BYTE_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign bus.tx_ready   = tx_ready_q;
  assign bus.ser_out    = ser_out_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_serial_byte_tx.sv
// Testbench for serial_byte_tx: two instances (no gap, 3-cycle gap) checked cycle by cycle
// against a frame-timeline model; honours SERIAL_BYTE_TX_PARITY_EN.
module tb_serial_byte_tx;
  localparam int GAP0 = 0;
  localparam int GAP1 = 3;
`ifdef SERIAL_BYTE_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct packed {
    logic ready;
    logic ser_out;
    logic ser_valid;
    logic frame_done;
    logic busy;
  } out_t;

  localparam out_t IDLE_O = '{ready: 1'b1, ser_out: 1'b0, ser_valid: 1'b0, frame_done: 1'b0, busy: 1'b0};

  logic       clk_sr = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;

  int n_checks = 0;
  int n_errors = 0;

  serial_byte_tx_if #(.WIDTH(8)) if0 ();
  serial_byte_tx_if #(.WIDTH(8)) if1 ();

  assign if0.tx_valid = tx_valid;
  assign if0.tx_data  = tx_data;
  assign if1.tx_valid = tx_valid;
  assign if1.tx_data  = tx_data;

  serial_byte_tx #(.WIDTH(8), .GAP_CYCLES(GAP0)) dut0 (.clk_sr(clk_sr), .rst(rst), .bus(if0));
  serial_byte_tx #(.WIDTH(8), .GAP_CYCLES(GAP1)) dut1 (.clk_sr(clk_sr), .rst(rst), .bus(if1));

  always #5 clk_sr = ~clk_sr;

  // Expected output timeline per instance: one entry per cycle of a pending frame.
  out_t       q0[$], q1[$];
  logic [7:0] dq0[$], dq1[$];
  out_t       cur0 = IDLE_O, cur1 = IDLE_O;
  logic [8:0] ds0 = '0, ds1 = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int inst, input logic [7:0] d);
    out_t f[$];
    int   gap;
    gap = (inst == 0) ? GAP0 : GAP1;
    for (int i = 0; i < 8; i++)
      f.push_back('{ready: 1'b0, ser_out: d[7-i], ser_valid: 1'b1,
                    frame_done: (i == 7) && !PAR, busy: 1'b1});
    if (PAR)
      f.push_back('{ready: 1'b0, ser_out: ^d, ser_valid: 1'b1, frame_done: 1'b1, busy: 1'b1});
    for (int g = 0; g < gap; g++)
      f.push_back('{ready: 1'b0, ser_out: 1'b0, ser_valid: 1'b0, frame_done: 1'b0, busy: 1'b1});
    foreach (f[i]) begin
      if (inst == 0) q0.push_back(f[i]);
      else           q1.push_back(f[i]);
    end
  endtask

  // Downstream shift register: captures ser_out at the edge ending a valid cycle;
  // at the frame's last bit its contents must equal the accepted word (plus parity).
  task automatic observe_downstream(input int inst);
    logic       v, b, fd;
    logic [8:0] ds;
    logic [7:0] d;
    int         sz;
    v  = (inst == 0) ? if0.ser_valid  : if1.ser_valid;
    b  = (inst == 0) ? if0.ser_out    : if1.ser_out;
    fd = (inst == 0) ? if0.frame_done : if1.frame_done;
    ds = (inst == 0) ? ds0 : ds1;
    if (v === 1'b1) ds = {ds[7:0], b};
    if (fd === 1'b1) begin
      sz = (inst == 0) ? dq0.size() : dq1.size();
      check($sformatf("dut%0d_frame_pending", inst), 32'(sz), 32'd1);
      if (sz > 0) begin
        d = (inst == 0) ? dq0.pop_front() : dq1.pop_front();
        if (PAR) check($sformatf("dut%0d_downstream", inst), 32'(ds), 32'({d, ^d}));
        else     check($sformatf("dut%0d_downstream", inst), 32'(ds[7:0]), 32'(d));
      end
    end
    if (inst == 0) ds0 = ds;
    else           ds1 = ds;
  endtask

  task automatic step();
    logic       acc0, acc1;
    logic [7:0] d;
    out_t       act0, act1;
    acc0 = cur0.ready && tx_valid && !rst;
    acc1 = cur1.ready && tx_valid && !rst;
    d    = tx_data;
    observe_downstream(0);
    observe_downstream(1);
    @(posedge clk_sr);
    #1;
    if (rst) begin
      q0.delete(); q1.delete(); dq0.delete(); dq1.delete();
    end else begin
      if (acc0) begin push_frame(0, d); dq0.push_back(d); end
      if (acc1) begin push_frame(1, d); dq1.push_back(d); end
    end
    cur0 = (q0.size() > 0) ? q0.pop_front() : IDLE_O;
    cur1 = (q1.size() > 0) ? q1.pop_front() : IDLE_O;
    act0 = '{if0.tx_ready, if0.ser_out, if0.ser_valid, if0.frame_done, if0.busy};
    act1 = '{if1.tx_ready, if1.ser_out, if1.ser_valid, if1.frame_done, if1.busy};
    check("dut0_outputs", 32'(act0), 32'(cur0));
    check("dut1_outputs", 32'(act1), 32'(cur1));
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    tx_valid = v;
    tx_data  = d;
    rst      = r;
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b1);
    repeat (2) step();
    drive(1'b0, 8'h00, 1'b0);
    step();

    drive(1'b1, 8'hA5, 1'b0);
    step();
    drive(1'b0, 8'hA5, 1'b0);
    repeat (16) step();

    drive(1'b1, 8'hFF, 1'b0);
    step();
    drive(1'b1, 8'h00, 1'b0);
    repeat (20) step();
    drive(1'b0, 8'h00, 1'b0);
    repeat (16) step();

    drive(1'b1, 8'h81, 1'b0);
    step();
    drive(1'b1, 8'h7E, 1'b0);
    repeat (13) step();
    drive(1'b0, 8'h7E, 1'b0);
    repeat (16) step();

    drive(1'b1, 8'hC3, 1'b0);
    step();
    drive(1'b0, 8'hC3, 1'b0);
    repeat (3) step();
    drive(1'b0, 8'hC3, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0);
    step();
    drive(1'b1, 8'h3C, 1'b0);
    step();
    drive(1'b0, 8'h3C, 1'b0);
    repeat (16) step();

    drive(1'b1, 8'h55, 1'b1);
    step();
    drive(1'b0, 8'h55, 1'b0);
    repeat (3) step();

    drive(1'b1, 8'h07, 1'b0);
    step();
    drive(1'b1, 8'h03, 1'b0);
    repeat (12) step();
    drive(1'b0, 8'h03, 1'b0);
    repeat (16) step();

    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 63) == 0);
      step();
    end
    drive(1'b0, 8'h00, 1'b0);
    repeat (16) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
